// File: rtl/bitty_pkg.sv
// rtl/bitty_pkg.sv - shared constants and FSM encoding for the bitty fetch path
package bitty_pkg;

  localparam int INSTR_W   = 16;
  localparam int RETIRED_W = 16;

  // Format bits [1:0]=11 with every other field zero.
  localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0003;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  function automatic logic is_busy(input logic [2:0] s);
    return (s == ST_FETCH) || (s == ST_WAIT) || (s == ST_EXEC);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with reset load and wrapping increment on retire
module fetch_pc_reg #(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc_q, pc_d;

  // Natural width overflow gives the modulo 2^ADDR_W wrap.
  always_comb begin
    pc_d = pc_q;
    if (inc_i) pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_VAL;
    else       pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer driving the run/done handshake; FETCH_HALT_EN adds HALTED
module fetch_unit
  import bitty_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic                 stop_i,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic                 mem_rd_o,
  input  logic [INSTR_W-1:0]   mem_data_i,
  output logic [INSTR_W-1:0]   instr_o,
  output logic                 run_o,
  input  logic                 done_i,
  output logic [ADDR_W-1:0]    pc_o,
  output logic                 busy_o,
  output logic                 halted_o,
  output logic [RETIRED_W-1:0] retired_o
);

  logic [2:0]           state_q, state_d;
  logic                 stop_pend_q, stop_pend_d;
  logic [INSTR_W-1:0]   instr_q;
  logic [RETIRED_W-1:0] retired_q;
  logic                 run_q, mem_rd_q, busy_q;
  logic                 retire;
  logic [ADDR_W-1:0]    pc;

  assign retire = (state_q == ST_EXEC) && done_i;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .inc_i (retire),
    .pc_o  (pc)
  );

  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      ST_IDLE: begin
        // A stop arriving with start still lets exactly one instruction run.
        if (start_i) begin
          state_d     = ST_FETCH;
          stop_pend_d = stop_i;
        end
      end
      ST_FETCH: begin
        stop_pend_d = stop_pend_q | stop_i;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        stop_pend_d = stop_pend_q | stop_i;
        state_d     = ST_EXEC;
`ifdef FETCH_HALT_EN
        if (mem_data_i == HALT_WORD) state_d = ST_HALTED;
`endif
      end
      ST_EXEC: begin
        stop_pend_d = stop_pend_q | stop_i;
        if (done_i) state_d = stop_pend_d ? ST_IDLE : ST_FETCH;
      end
`ifdef FETCH_HALT_EN
      ST_HALTED: state_d = ST_HALTED;
`endif
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) stop_pend_d = 1'b0;
  end

  // Outputs are registered from next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      stop_pend_q <= 1'b0;
      instr_q     <= '0;
      retired_q   <= '0;
      run_q       <= 1'b0;
      mem_rd_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      run_q       <= (state_d == ST_EXEC);
      mem_rd_q    <= (state_d == ST_FETCH);
      busy_q      <= is_busy(state_d);
      if (state_q == ST_WAIT) instr_q <= mem_data_i;
      if (retire && (retired_q != {RETIRED_W{1'b1}})) retired_q <= retired_q + 1'b1;
    end
  end

`ifdef FETCH_HALT_EN
  logic halted_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) halted_q <= 1'b0;
    else       halted_q <= (state_d == ST_HALTED);
  end

  assign halted_o = halted_q;
`else
  assign halted_o = 1'b0;
`endif

  assign mem_addr_o = pc;
  assign pc_o       = pc;
  assign mem_rd_o   = mem_rd_q;
  assign instr_o    = instr_q;
  assign run_o      = run_q;
  assign busy_o     = busy_q;
  assign retired_o  = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against a transaction-level model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data = 16'h0;
  logic [15:0] instr;
  logic        run, done, busy, halted;
  logic [7:0]  pc;
  logic [15:0] retired;

  logic        start_s = 1'b0, stop_s = 1'b0;
  logic [1:0]  mem_addr_s;
  logic        mem_rd_s;
  logic [15:0] mem_data_s = 16'h0;
  logic [15:0] instr_s;
  logic        run_s, done_s, busy_s, halted_s;
  logic [1:0]  pc_s;
  logic [15:0] retired_s;

  logic [15:0] mem  [256];
  logic [15:0] smem [4];

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(8), .RESET_PC(0)) u_dut (
    .clk(clk), .reset(reset), .start_i(start), .stop_i(stop),
    .mem_addr_o(mem_addr), .mem_rd_o(mem_rd), .mem_data_i(mem_data),
    .instr_o(instr), .run_o(run), .done_i(done), .pc_o(pc),
    .busy_o(busy), .halted_o(halted), .retired_o(retired)
  );

  fetch_unit #(.ADDR_W(2), .RESET_PC(3)) u_small (
    .clk(clk), .reset(reset), .start_i(start_s), .stop_i(stop_s),
    .mem_addr_o(mem_addr_s), .mem_rd_o(mem_rd_s), .mem_data_i(mem_data_s),
    .instr_o(instr_s), .run_o(run_s), .done_i(done_s), .pc_o(pc_s),
    .busy_o(busy_s), .halted_o(halted_s), .retired_o(retired_s)
  );

  // Synchronous instruction memories: data the cycle after the read strobe.
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];
  always @(posedge clk) if (mem_rd_s) mem_data_s <= smem[mem_addr_s];

  // Control-unit models: done in the exec_len-th run-high cycle.
  int   exec_len = 3;
  int   run_cnt = 0, run_cnt_s = 0;
  logic done_m = 1'b0, done_f = 1'b0, done_ms = 1'b0;
  assign done   = done_m | done_f;
  assign done_s = done_ms;

  always @(negedge clk) begin
    if (run) begin run_cnt = run_cnt + 1; done_m = (run_cnt == exec_len); end
    else begin run_cnt = 0; done_m = 1'b0; end
    if (run_s) begin run_cnt_s = run_cnt_s + 1; done_ms = (run_cnt_s == 3); end
    else begin run_cnt_s = 0; done_ms = 1'b0; end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; start_s = 1'b0; stop_s = 1'b0; done_f = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 40) begin tick(); k++; end
    check(tag, busy, 1'b0);
  endtask

  function automatic logic [15:0] rword();
    logic [15:0] w = 16'($urandom);
    if (w == 16'h0003) w = 16'h0004;
    return w;
  endfunction

  // Transaction-level reference for the random phase.
  logic       mon_en = 1'b0;
  logic [7:0] m_pc = 8'h0;
  int         m_ret = 0;
  logic       m_pend = 1'b0;
  logic       p_idle = 1'b0, p_start = 1'b0, p_retire = 1'b0, p_run = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (p_retire) begin
          m_pc  = m_pc + 8'd1;
          m_ret = m_ret + 1;
          check("rt_pc", pc, m_pc);
          check("rt_count", retired, m_ret);
          check("rt_busy", busy, !m_pend);
          check("rt_next_fetch", mem_rd, !m_pend);
          m_pend = 1'b0;
        end
        if (p_idle) check("idle_start", mem_rd, p_start);
        if (mem_rd) check("fetch_addr", mem_addr, m_pc);
        if (run && !p_run) check("exec_instr", instr, mem[m_pc]);
        if (busy && stop) m_pend = 1'b1;
        if (!busy && start) m_pend = stop;
        p_idle   = !busy;
        p_start  = start;
        p_retire = run && done;
        p_run    = run;
      end
    end
  end

  initial begin
    int n, low, gmin, gmax, k;
    logic seen_run, sent, ran2;
    logic [1:0] fa [$];

    for (int i = 0; i < 256; i++) mem[i] = rword();
    mem[0] = 16'h2408;

    // Reset values while reset is held.
    tick();
    check("rst_run", run, 1'b0);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_pc", pc, 8'd0);
    check("rst_instr", instr, 16'h0);
    check("rst_retired", retired, 16'd0);
    check("rst_small_pc", pc_s, 2'd3);
    do_reset();

    // Single instruction latency.
    start = 1'b1; tick(); start = 1'b0;
    check("t1_mem_rd", mem_rd, 1'b1);
    check("t1_addr", mem_addr, 8'd0);
    check("t1_busy", busy, 1'b1);
    tick();
    check("t1_wait_rd", mem_rd, 1'b0);
    check("t1_wait_run", run, 1'b0);
    tick();
    check("t1_run", run, 1'b1);
    check("t1_instr", instr, 16'h2408);
    tick(); check("t1_run2", run, 1'b1);
    tick(); check("t1_run3", run, 1'b1);
    stop = 1'b1;
    tick(); stop = 1'b0;
    check("t1_run_drop", run, 1'b0);
    check("t1_pc", pc, 8'd1);
    check("t1_retired", retired, 16'd1);
    wait_idle("t1_idle");

    // Four back-to-back instructions.
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    check("t2_first_rd", mem_rd, 1'b1);
    n = 0; low = 0; gmin = 99; gmax = 0; seen_run = 1'b0; sent = 1'b0;
    for (int j = 0; j < 100 && retired < 16'd4; j++) begin
      if (retired == 16'd3 && !sent) begin stop = 1'b1; sent = 1'b1; end
      else stop = 1'b0;
      tick(); n++;
      if (run) begin
        if (seen_run && low > 0) begin
          if (low < gmin) gmin = low;
          if (low > gmax) gmax = low;
        end
        seen_run = 1'b1; low = 0;
      end else low++;
    end
    stop = 1'b0;
    check("t2_cycles", n, 20);
    check("t2_gap_min", gmin, 2);
    check("t2_gap_max", gmax, 2);
    check("t2_pc", pc, 8'd4);
    check("t2_busy", busy, 1'b0);

    // Stop in the second EXEC cycle.
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("t4_exec", run, 1'b1);
    tick(); stop = 1'b1;
    tick(); stop = 1'b0;
    tick();
    check("t4_busy", busy, 1'b0);
    check("t4_run", run, 1'b0);
    check("t4_pc", pc, 8'd5);
    tick();
    check("t4_idle_rd", mem_rd, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    check("t4_resume_rd", mem_rd, 1'b1);
    check("t4_resume_addr", mem_addr, 8'd5);
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle("t4_idle");

    // Small PC wraps from 3 to 0.
    do_reset();
    for (int i = 0; i < 4; i++) smem[i] = rword();
    start_s = 1'b1; tick(); start_s = 1'b0;
    sent = 1'b0; k = 0;
    while (retired_s < 16'd2 && k < 60) begin
      if (mem_rd_s) fa.push_back(mem_addr_s);
      if (retired_s == 16'd1 && !sent) begin stop_s = 1'b1; sent = 1'b1; end
      else stop_s = 1'b0;
      tick(); k++;
    end
    stop_s = 1'b0;
    check("t3_nfetch", fa.size(), 2);
    if (fa.size() >= 2) begin
      check("t3_addr0", fa[0], 2'd3);
      check("t3_addr1", fa[1], 2'd0);
    end
    check("t3_pc", pc_s, 2'd1);
    check("t3_busy", busy_s, 1'b0);

    // Reset in the middle of EXEC, then a stray done.
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    k = 0;
    while (retired < 16'd1 && k < 20) begin tick(); k++; end
    check("t5_first_retire", retired, 16'd1);
    tick(); tick();
    check("t5_exec", run, 1'b1);
    tick();
    reset = 1'b1;
    #1;
    check("t5_run", run, 1'b0);
    check("t5_pc", pc, 8'd0);
    check("t5_retired", retired, 16'd0);
    check("t5_busy", busy, 1'b0);
    tick(); reset = 1'b0; done_f = 1'b1;
    tick(); tick(); done_f = 1'b0;
    check("t5_late_pc", pc, 8'd0);
    check("t5_late_retired", retired, 16'd0);
    check("t5_late_busy", busy, 1'b0);

    // Halt word at address 2.
    do_reset();
    mem[2] = 16'h0003;
    start = 1'b1; tick(); start = 1'b0;
    ran2 = 1'b0; sent = 1'b0; k = 0;
`ifdef FETCH_HALT_EN
    while (!halted && k < 60) begin
      if (run && pc == 8'd2) ran2 = 1'b1;
      tick(); k++;
    end
    check("t6_halted", halted, 1'b1);
    check("t6_ran2", ran2, 1'b0);
    check("t6_pc", pc, 8'd2);
    check("t6_retired", retired, 16'd2);
    check("t6_busy", busy, 1'b0);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("t6_start_ignored", mem_rd, 1'b0);
    tick();
    check("t6_still_halted", halted, 1'b1);
    check("t6_pc_hold", pc, 8'd2);
`else
    while (retired < 16'd3 && k < 60) begin
      if (run && pc == 8'd2) ran2 = 1'b1;
      if (retired == 16'd2 && !sent) begin stop = 1'b1; sent = 1'b1; end
      else stop = 1'b0;
      tick(); k++;
    end
    stop = 1'b0;
    check("t6_halted", halted, 1'b0);
    check("t6_ran2", ran2, 1'b1);
    check("t6_pc", pc, 8'd3);
    check("t6_retired", retired, 16'd3);
    check("t6_busy", busy, 1'b0);
`endif

    // Random start/stop/latency against the reference model.
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = rword();
    m_pc = 8'h0; m_ret = 0; m_pend = 1'b0;
    mon_en = 1'b1;
    for (int j = 0; j < 2000; j++) begin
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 24) == 0);
      if (!run && mem_rd) exec_len = $urandom_range(1, 4);
      tick();
    end
    start = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
    wait_idle("rand_idle");
    tick(); tick();
    mon_en = 1'b0;
    exec_len = 3;
    check("rand_model_retired", retired, m_ret);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
